bram_responder: RTL
===================

// Module: bram_responder
// PURPOSE
//  Native single-port BRAM responder: the memory-side endpoint for the bram_* port driven by our AXIS<->BRAM bridge.
//  Holds a 2**ADDR_WIDTH x DATA_WIDTH array with byte-write enables, a pipelined read path and access counters.
//  Used as a synthesizable BRAM stand-in in sims and on targets without the vendor BRAM port wrapper.
// PARAMETERS
//  C_BRAM_ADDR_WIDTH   12  word address width; depth = 2**C_BRAM_ADDR_WIDTH
//  C_BRAM_DATA_WIDTH   64  data width, multiple of 8
//  C_BRAM_READ_LATENCY 1   cycles from read request to bram_dout_valid, legal 1..4
//  C_BRAM_WRITE_MODE   0   0 = READ_FIRST (old data), 1 = WRITE_FIRST (merged new data)
//  C_BRAM_CNT_WIDTH    32  width of statistics counters
// PORTS
//  clk             in   1      sole clock; all logic on posedge
//  reset           in   1      asynchronous, active-high reset
//  bram_addr       in   AW     word address, shared by read and write
//  bram_din        in   DW     write data
//  bram_we         in   DW/8   byte write enables; write when any bit set, independent of bram_en
//  bram_en         in   1      read enable
//  bram_dout       out  DW     read data
//  bram_dout_valid out  1      one-cycle pulse per returned read word
//  stat_clear      in   1      synchronous clear of both counters
//  stat_rd_count   out  CW     reads accepted (saturating)
//  stat_wr_count   out  CW     write cycles accepted (saturating)
//  par_err         out  1      parity error pulse, aligned with bram_dout_valid
//  par_err_addr    out  AW     address of most recent parity error
//  par_inject      in   1      corrupt stored parity of bytes written this cycle
// BEHAVIOUR
//  Reset: bram_dout=0, bram_dout_valid=0, counters=0, par_err=0, par_err_addr=0, read pipe flushed.
//   Array contents are NOT reset and survive reset; reads in flight at reset are discarded, never returned.
//  Read: bram_en=1 at edge T samples bram_addr; data on bram_dout with bram_dout_valid=1 in cycle T+LATENCY.
//   Back-to-back reads every cycle supported; no stalls, no backpressure.
//  bram_dout holds its last returned value while bram_dout_valid=0 (no zeroing).
//  Write: bram_we!=0 at edge T updates only enabled bytes at bram_addr; visible to a read at edge T+1.
//  Same-cycle read+write, same address: READ_FIRST returns pre-write word; WRITE_FIRST returns the word
//   with enabled bytes from bram_din and old bytes elsewhere.
//  Address arithmetic is full-width; no out-of-range case exists.
//  Counters: +1 per read (bram_en), +1 per write (bram_we!=0); both can increment in one cycle.
//   Saturate at all-ones; stat_clear wins over a same-cycle increment (result 0).
// CONFIGURATION
//  BRAM_RESPONDER_PARITY_EN defined: one even-parity bit stored per byte, computed on write per enabled byte.
//   par_inject=1 with a write stores inverted parity for the enabled bytes only.
//   Read checks all bytes; any mismatch -> par_err=1 with that bram_dout_valid, par_err_addr <= read address.
//   Data is returned unmodified (detect only, no correction).
//  Undefined: no parity storage; par_err=0, par_err_addr=0 constant, par_inject ignored.
// STRUCTURE
//  Package axis_bram_pkg: WRITE_MODE encodings (READ_FIRST=0, WRITE_FIRST=1), byte-parity function,
//   legal READ_LATENCY range constants shared with the bridge.
//  Sub-module bram_responder_rdpipe: LATENCY-deep shift of {valid, data, addr, parity_err}, async reset on valid.
//  Top holds the array, write-byte merge, counters and parity generation.
// TESTING
//  1. Write 0x0123456789ABCDEF @0x010 (we=0xFF), read @0x010 next cycle, LATENCY=1 -> valid at T+1, dout=0x0123456789ABCDEF.
//  2. we=0x0F, din=0xFFFFFFFF_FFFFFFFF over 0x0123456789ABCDEF -> readback 0x01234567FFFFFFFF.
//  3. Same-cycle R+W @0x020 old=0x11.. new=0x22..: MODE0 -> 0x11..; MODE1 -> 0x22..; next read 0x22.. both.
//  4. LATENCY=3, reads @1,2,3 on consecutive cycles, reset asserted 1 cycle after last -> no valid pulses; array intact after.
//  5. Counter CW=4: 16 reads -> stat_rd_count=15 saturated; stat_clear with a read same cycle -> 0.
//  6. PARITY_EN: write @0x030 with par_inject=1 -> read gives par_err=1, par_err_addr=0x030, data unchanged; rewrite clears.

Source files
------------

// File: rtl/axis_bram_pkg.sv
// Shared definitions for the AXIS<->BRAM bridge and its BRAM responder.
// Contents: write-mode encodings, legal read-latency range, byte parity helper.
package axis_bram_pkg;

    // Write-mode encodings for C_BRAM_WRITE_MODE
    localparam int unsigned WRITE_MODE_READ_FIRST  = 0;
    localparam int unsigned WRITE_MODE_WRITE_FIRST = 1;

    // Legal range of C_BRAM_READ_LATENCY
    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 4;

    // Even-parity bit for one byte: makes the 9-bit total have an even count of ones
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/bram_responder_rdpipe.sv
// Read-return pipeline of the BRAM responder.
// Shifts {valid, data, addr, parity_err} through LATENCY register stages.
// Data holds between valid words; the final address stage only loads on a
// parity error so it presents the address of the most recent error.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   i_valid/i_data/i_addr/i_perr   stage input (one read word per valid)
//   o_valid/o_data        returned word and its one-cycle valid pulse
//   o_err                 parity error pulse aligned with o_valid
//   o_err_addr            address of most recent parity error
module bram_responder_rdpipe #(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_perr,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_err_addr
);

    logic                  r_vld [1:LATENCY];
    logic [DATA_WIDTH-1:0] r_dat [1:LATENCY];
    logic [ADDR_WIDTH-1:0] r_adr [1:LATENCY];
    logic                  r_err [1:LATENCY];

    logic                  w_vld [1:LATENCY];
    logic [DATA_WIDTH-1:0] w_dat [1:LATENCY];
    logic [ADDR_WIDTH-1:0] w_adr [1:LATENCY];
    logic                  w_err [1:LATENCY];

    // Stage inputs: stage 1 takes the pipe input, later stages the previous stage
    always_comb begin
        w_vld[1] = i_valid;
        w_dat[1] = i_data;
        w_adr[1] = i_addr;
        w_err[1] = i_perr;
        for (int i = 2; i <= int'(LATENCY); i++) begin
            w_vld[i] = r_vld[i-1];
            w_dat[i] = r_dat[i-1];
            w_adr[i] = r_adr[i-1];
            w_err[i] = r_err[i-1];
        end
    end

    // Stage registers; payload only moves with a valid word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= int'(LATENCY); i++) begin
                r_vld[i] <= 1'b0;
                r_dat[i] <= '0;
                r_adr[i] <= '0;
                r_err[i] <= 1'b0;
            end
        end else begin
            for (int i = 1; i <= int'(LATENCY); i++) begin
                r_vld[i] <= w_vld[i];
                if (w_vld[i]) begin
                    r_dat[i] <= w_dat[i];
                    r_err[i] <= w_err[i];
                    // last stage keeps the most recent error address
                    if ((i < int'(LATENCY)) || w_err[i]) begin
                        r_adr[i] <= w_adr[i];
                    end
                end
            end
        end
    end

    assign o_valid    = r_vld[LATENCY];
    assign o_data     = r_dat[LATENCY];
    assign o_err      = r_vld[LATENCY] & r_err[LATENCY];
    assign o_err_addr = r_adr[LATENCY];

endmodule

// File: rtl/bram_responder.sv
// Native single-port BRAM responder: memory-side endpoint of the bridge's bram_* port.
// 2**C_BRAM_ADDR_WIDTH x C_BRAM_DATA_WIDTH array with byte write enables,
// a registered read followed by C_BRAM_READ_LATENCY return stages, and
// saturating read/write counters. Array contents are not reset.
// Build option: define BRAM_RESPONDER_PARITY_EN to store one even-parity bit
// per byte and flag mismatches on read (detect only).
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   bram_addr/bram_din/bram_we  word address, write data, byte write enables
//   bram_en                     read enable
//   bram_dout/bram_dout_valid   read data (held) and one-cycle valid pulse
//   stat_clear                  synchronous clear of both counters
//   stat_rd_count/stat_wr_count saturating access counters
//   par_err/par_err_addr        parity error pulse and last error address
//   par_inject                  store inverted parity for bytes written this cycle
module bram_responder
    import axis_bram_pkg::*;
#(
    parameter int unsigned C_BRAM_ADDR_WIDTH   = 12,
    parameter int unsigned C_BRAM_DATA_WIDTH   = 64,
    parameter int unsigned C_BRAM_READ_LATENCY = 1,
    parameter int unsigned C_BRAM_WRITE_MODE   = 0,
    parameter int unsigned C_BRAM_CNT_WIDTH    = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [C_BRAM_ADDR_WIDTH-1:0]   bram_addr,
    input  logic [C_BRAM_DATA_WIDTH-1:0]   bram_din,
    input  logic [C_BRAM_DATA_WIDTH/8-1:0] bram_we,
    input  logic                           bram_en,
    output logic [C_BRAM_DATA_WIDTH-1:0]   bram_dout,
    output logic                           bram_dout_valid,
    input  logic                           stat_clear,
    output logic [C_BRAM_CNT_WIDTH-1:0]    stat_rd_count,
    output logic [C_BRAM_CNT_WIDTH-1:0]    stat_wr_count,
    output logic                           par_err,
    output logic [C_BRAM_ADDR_WIDTH-1:0]   par_err_addr,
    input  logic                           par_inject
);

    localparam int unsigned AW    = C_BRAM_ADDR_WIDTH;
    localparam int unsigned DW    = C_BRAM_DATA_WIDTH;
    localparam int unsigned NB    = C_BRAM_DATA_WIDTH / 8;
    localparam int unsigned CW    = C_BRAM_CNT_WIDTH;
    localparam int unsigned DEPTH = 1 << C_BRAM_ADDR_WIDTH;

    // Elaboration-time parameter checks
    if ((C_BRAM_READ_LATENCY < READ_LATENCY_MIN) ||
        (C_BRAM_READ_LATENCY > READ_LATENCY_MAX)) begin : g_bad_latency
        $error("bram_responder: C_BRAM_READ_LATENCY out of range");
    end
    if ((C_BRAM_DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("bram_responder: C_BRAM_DATA_WIDTH must be a multiple of 8");
    end

    logic [DW-1:0] r_mem [DEPTH];

    logic [DW-1:0] w_old;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] w_rd_data;

    logic          r_s0_vld;
    logic [DW-1:0] r_s0_data;
    logic [AW-1:0] r_s0_addr;
    logic          w_s0_perr;

    logic [CW-1:0] r_rd_cnt;
    logic [CW-1:0] r_wr_cnt;

    // Byte merge of the write into the addressed word; also the WRITE_FIRST read value
    always_comb begin
        w_old    = r_mem[bram_addr];
        w_merged = w_old;
        for (int b = 0; b < int'(NB); b++) begin
            if (bram_we[b]) begin
                w_merged[b*8 +: 8] = bram_din[b*8 +: 8];
            end
        end
        w_rd_data = (C_BRAM_WRITE_MODE == WRITE_MODE_WRITE_FIRST) ? w_merged : w_old;
    end

    // Array write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (|bram_we) begin
            r_mem[bram_addr] <= w_merged;
        end
    end

    // Read sample stage: captures the word at the request edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_vld  <= 1'b0;
            r_s0_data <= '0;
            r_s0_addr <= '0;
        end else begin
            r_s0_vld <= bram_en;
            if (bram_en) begin
                r_s0_data <= w_rd_data;
                r_s0_addr <= bram_addr;
            end
        end
    end

`ifdef BRAM_RESPONDER_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] r_s0_par;
    logic [NB-1:0] w_old_par;
    logic [NB-1:0] w_merged_par;
    logic [NB-1:0] w_rd_par;
    logic [NB-1:0] w_s0_calc;

    // Parity merge mirrors the data merge; injection flips enabled bytes only
    always_comb begin
        w_old_par    = r_par[bram_addr];
        w_merged_par = w_old_par;
        for (int b = 0; b < int'(NB); b++) begin
            if (bram_we[b]) begin
                w_merged_par[b] = byte_parity(bram_din[b*8 +: 8]) ^ par_inject;
            end
        end
        w_rd_par = (C_BRAM_WRITE_MODE == WRITE_MODE_WRITE_FIRST) ? w_merged_par : w_old_par;
        for (int b = 0; b < int'(NB); b++) begin
            w_s0_calc[b] = byte_parity(r_s0_data[b*8 +: 8]);
        end
        w_s0_perr = |(w_s0_calc ^ r_s0_par);
    end

    always_ff @(posedge clk) begin
        if (|bram_we) begin
            r_par[bram_addr] <= w_merged_par;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_par <= '0;
        end else if (bram_en) begin
            r_s0_par <= w_rd_par;
        end
    end
`else
    logic w_unused_par_inject;
    assign w_unused_par_inject = par_inject;
    assign w_s0_perr           = 1'b0;
`endif

    bram_responder_rdpipe #(
        .LATENCY    (C_BRAM_READ_LATENCY),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) u_rdpipe (
        .clk        (clk),
        .rst        (reset),
        .i_valid    (r_s0_vld),
        .i_data     (r_s0_data),
        .i_addr     (r_s0_addr),
        .i_perr     (w_s0_perr),
        .o_valid    (bram_dout_valid),
        .o_data     (bram_dout),
        .o_err      (par_err),
        .o_err_addr (par_err_addr)
    );

    // Saturating access counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (stat_clear) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (bram_en && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + CW'(1);
            end
            if ((|bram_we) && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + CW'(1);
            end
        end
    end

    assign stat_rd_count = r_rd_cnt;
    assign stat_wr_count = r_wr_cnt;

endmodule
